// File: rtl/flag_sched_pkg.sv
// Shared definitions for the flag-crossing scheduler family.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, index-width helper, legal parameter ranges.
package flag_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Index width for n items; a single item still needs a 1-bit index.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The destination synchronizer needs at least one idle cycle between toggles.
  localparam int GAP_MIN   = 1;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of pend_i at or after ptr_i+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports: pend_i (request vector), ptr_i (last granted index),
//        grant_o (one-hot), idx_o (binary index of grant), any_o (grant valid).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pend_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    // k runs 1..N so the just-served index is considered last.
    for (int k = 1; k <= N; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % N);
      if (!any_o && pend_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/flag_cross_scheduler.sv
// Shares one toggle-based flag crossing among N_REQ requesters (round-robin).
// Latency: req_i at cycle t -> pend at t+1 -> flag_o/grant_o/id_o at t+2 when idle.
// Backpressure: events are latched in pend and merged if repeated; flag_o is
//   spaced by exactly GAP idle cycles, so bursts wait rather than drop.
//
// Ports: clk/rst (sync active-high), req_i (event pulses), grant_o (one-hot with
//   flag), flag_o (1-cycle pulse), id_o (held index), pend_o (pending vector),
//   busy_o (ISSUE/HOLD), merge_o (repeated event folded into a pending bit).
module flag_cross_scheduler
  import flag_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int GAP   = 3,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             flag_o,
  output logic [ID_W-1:0]  id_o,
  output logic [N_REQ-1:0] pend_o,
  output logic             busy_o,
  output logic             merge_o
);

  localparam int CNT_W = id_width(GAP + 1);

  if (GAP < GAP_MIN) begin : g_gap_chk
    $error("flag_cross_scheduler: GAP must be >= 1");
  end
  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_nreq_chk
    $error("flag_cross_scheduler: N_REQ must be in 2..16");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             flag_q, flag_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             merge_q, merge_d;
  logic [N_REQ-1:0] clr;

  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .pend_i  (pend_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    flag_d  = 1'b0;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    clr     = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ISSUE;
          grant_d = arb_grant;
          flag_d  = 1'b1;
          id_d    = arb_idx;
          ptr_d   = arb_idx;
          clr     = arb_grant;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        cnt_d   = CNT_W'(GAP);
      end
      HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last idle cycle: pick now so the next flag lands exactly GAP+1 after.
        if (cnt_q == CNT_W'(1)) begin
          if (arb_any) begin
            state_d = ISSUE;
            grant_d = arb_grant;
            flag_d  = 1'b1;
            id_d    = arb_idx;
            ptr_d   = arb_idx;
            clr     = arb_grant;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear: an event arriving with its own grant re-pends.
    pend_d  = (pend_q & ~clr) | req_i;
    merge_d = |(req_i & pend_q & ~clr);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      flag_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      merge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      flag_q  <= flag_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      merge_q <= merge_d;
    end
  end

  assign grant_o = grant_q;
  assign flag_o  = flag_q;
  assign id_o    = id_q;
  assign pend_o  = pend_q;
  assign busy_o  = busy_q;
  assign merge_o = merge_q;

endmodule
